usb_ls_xact_sched: RTL

- Frame-synchronous transaction scheduler that shares one USB_LS_PHY send/receive interface between two requesters: requester 0 is the control/enumeration engine and requester 1 is the interrupt-IN report poller.
- Issues at most one transaction per 1 ms frame and routes the handshake/data PID back to the granted requester.
- Applies a per-transaction frame timeout and a starvation guard for requester 1.
- Sits between the HID sequencing logic and USB_LS_PHY.

---
 rtl/usb_ls_pkg.sv | 54 +++++
 rtl/usb_ls_xact_sched_if.sv | 34 +++
 rtl/usb_toggle_edge.sv | 19 +
 rtl/usb_ls_xact_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/usb_ls_pkg.sv
// Shared types for the low-speed USB transaction scheduler:
// PIDs, result codes, field widths and the PID decoder.
package usb_ls_pkg;

  localparam int CTRL_W = 32;
  localparam int CSZ_W  = 6;
  localparam int DATA_W = 96;
  localparam int DSZ_W  = 7;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {
    RSP_ACK     = 3'd0,
    RSP_NAK     = 3'd1,
    RSP_STALL   = 3'd2,
    RSP_DATA    = 3'd3,
    RSP_TIMEOUT = 3'd4,
    RSP_DISC    = 3'd5
  } rsp_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic hit;
    rsp_e st;
  } pid_dec_t;

  function automatic pid_dec_t pid_decode(
    input logic [7:0] pid
  );
    pid_dec_t d;
    d.hit = 1'b1;
    d.st  = RSP_ACK;
    unique case (1'b1)
      (pid == PID_ACK):   d.st = RSP_ACK;
      (pid == PID_NAK):   d.st = RSP_NAK;
      (pid == PID_STALL): d.st = RSP_STALL;
      (pid == PID_DATA0 ||
       pid == PID_DATA1): d.st = RSP_DATA;
      default:            d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/usb_ls_xact_sched_if.sv
// PHY send/receive bundle between the scheduler (master)
// and the low-speed PHY (slave).
interface usb_ls_xact_sched_if;
  import usb_ls_pkg::*;

  logic              phy_send_out;
  logic [CTRL_W-1:0] phy_ctrl;
  logic [CSZ_W-1:0]  phy_ctrl_size;
  logic [DATA_W-1:0] phy_data;
  logic [DSZ_W-1:0]  phy_data_size;
  logic              phy_recv_in;
  logic [7:0]        phy_last_pid;

  modport master (
    output phy_send_out,
    output phy_ctrl,
    output phy_ctrl_size,
    output phy_data,
    output phy_data_size,
    input  phy_recv_in,
    input  phy_last_pid
  );

  modport slave (
    input  phy_send_out,
    input  phy_ctrl,
    input  phy_ctrl_size,
    input  phy_data,
    input  phy_data_size,
    output phy_recv_in,
    output phy_last_pid
  );

endinterface

// File: rtl/usb_toggle_edge.sv
// Toggle-to-pulse detector: pulses for one cycle whenever
// the input level differs from the level seen last cycle.
module usb_toggle_edge (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic pulse
);

  logic seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seen <= 1'b0;
    else       seen <= tgl;
  end

  assign pulse = tgl ^ seen;

endmodule

// File: rtl/usb_ls_xact_sched.sv
// Frame-synchronous scheduler sharing one low-speed PHY
// between the control engine (req0) and the IN poller (req1).
module usb_ls_xact_sched
  import usb_ls_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 3,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              connected,
  input  logic              frame_in,
  input  logic              req0_valid,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [CSZ_W-1:0]  req0_ctrl_size,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DSZ_W-1:0]  req0_data_size,
  input  logic              req1_valid,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [CSZ_W-1:0]  req1_ctrl_size,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DSZ_W-1:0]  req1_data_size,
  output logic              done0,
  output logic              done1,
  output logic [2:0]        rsp_status,
  output logic [7:0]        rsp_pid,
  output logic [1:0]        grant,
  output logic              busy,
  usb_ls_xact_sched_if.master phy
);

  localparam logic [3:0] TF = 4'(TIMEOUT_FRAMES);
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [1:0] grant_d;
  logic [3:0] tmo_q, tmo_d;
  logic [3:0] starve_q, starve_d;
  rsp_e       st_q, st_d;
  logic [7:0] pid_q, pid_d;
  logic [1:0] done_q, done_d;
  rsp_e       rsp_q, rsp_d;
  logic [7:0] rpid_d;
  logic       tick, rx, ld;
  pid_dec_t   dec;

  usb_toggle_edge u_frame (
    .clk   (clk),
    .reset (reset),
    .tgl   (frame_in),
    .pulse (tick)
  );

  usb_toggle_edge u_recv (
    .clk   (clk),
    .reset (reset),
    .tgl   (phy.phy_recv_in),
    .pulse (rx)
  );

  assign busy       = (state_q != S_IDLE);
  assign done0      = done_q[0];
  assign done1      = done_q[1];
  assign rsp_status = rsp_q;
  assign dec        = pid_decode(phy.phy_last_pid);
  assign ld         = connected && (state_q == S_SEND);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    st_d     = st_q;
    pid_d    = pid_q;
    done_d   = '0;
    rsp_d    = rsp_q;
    rpid_d   = rsp_pid;
    if (!connected) begin
      state_d = S_IDLE;
      grant_d = '0;
      if (busy) begin
        done_d   = grant;
        rsp_d    = RSP_DISC;
        rpid_d   = '0;
        starve_d = '0;
      end
    end else begin
      if (tick && !req1_valid) starve_d = '0;
      unique case (state_q)
        S_IDLE: if (tick) begin
          if (req1_valid &&
              (starve_q == SL || !req0_valid)) begin
            grant_d  = 2'b10;
            state_d  = S_SEND;
            starve_d = '0;
          end else if (req0_valid) begin
            grant_d = 2'b01;
            state_d = S_SEND;
            if (req1_valid && starve_q != SL)
              starve_d = starve_q + 4'd1;
          end
        end
        S_SEND: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A decoded response beats a same-cycle timeout tick
          if (rx && dec.hit) begin
            st_d    = dec.st;
            pid_d   = phy.phy_last_pid;
            state_d = S_DONE;
          end else if (tick) begin
            tmo_d = tmo_q + 4'd1;
            if (tmo_d == TF) begin
              st_d    = RSP_TIMEOUT;
              pid_d   = '0;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          done_d  = grant;
          rsp_d   = st_q;
          rpid_d  = pid_q;
          grant_d = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant    <= '0;
      tmo_q    <= '0;
      starve_q <= '0;
      st_q     <= RSP_ACK;
      pid_q    <= '0;
      done_q   <= '0;
      rsp_q    <= RSP_ACK;
      rsp_pid  <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
      st_q     <= st_d;
      pid_q    <= pid_d;
      done_q   <= done_d;
      rsp_q    <= rsp_d;
      rsp_pid  <= rpid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phy.phy_send_out  <= 1'b0;
      phy.phy_ctrl      <= '0;
      phy.phy_ctrl_size <= '0;
      phy.phy_data      <= '0;
      phy.phy_data_size <= '0;
    end else if (ld) begin
      phy.phy_send_out  <= ~phy.phy_send_out;
      phy.phy_ctrl      <= grant[1] ? req1_ctrl : req0_ctrl;
      phy.phy_ctrl_size <= grant[1] ? req1_ctrl_size
                                    : req0_ctrl_size;
      phy.phy_data      <= grant[1] ? req1_data : req0_data;
      phy.phy_data_size <= grant[1] ? req1_data_size
                                    : req0_data_size;
    end
  end

endmodule
